// File: rtl/updown_digit_counter.sv
// Multi-digit up/down counter with per-digit radix arithmetic, clamped load,
// wrap/saturate end-of-range policy and registered status flags.
module updown_digit_counter #(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic                  sat_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  zero_o,
  output logic                  at_max_o,
  output logic                  wrap_o,
  output logic                  load_err_o
);

  localparam logic [3:0] MAXD = 4'(RADIX - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                zero_q, zero_d;
  logic                at_max_q, at_max_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;

  // carry[i]/borrow[i]: all digits below i are at max / at zero
  logic [DIGITS:0]     carry, borrow;

  always_comb begin
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      carry[i+1]  = carry[i]  & (count_q[4*i +: 4] == MAXD);
      borrow[i+1] = borrow[i] & (count_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load_i) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (load_val_i[4*i +: 4] > MAXD) begin
          count_d[4*i +: 4] = MAXD;
          load_err_d        = 1'b1;
        end else begin
          count_d[4*i +: 4] = load_val_i[4*i +: 4];
        end
      end
    end else if (en_i) begin
      if (mode_i) begin
        if (carry[DIGITS]) begin
          if (!sat_i) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (carry[i])
              count_d[4*i +: 4] = (count_q[4*i +: 4] == MAXD) ? 4'd0
                                                              : count_q[4*i +: 4] + 4'd1;
          end
        end
      end else begin
        if (borrow[DIGITS]) begin
          if (!sat_i) begin
            for (int i = 0; i < DIGITS; i++) count_d[4*i +: 4] = MAXD;
            wrap_d = 1'b1;
          end
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (borrow[i])
              count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? MAXD
                                                              : count_q[4*i +: 4] - 4'd1;
          end
        end
      end
    end
  end

  // Flags follow the next count so they line up with count_o on the same cycle
  always_comb begin
    zero_d   = (count_d == '0);
    at_max_d = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      at_max_d = at_max_d & (count_d[4*i +: 4] == MAXD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      zero_q     <= 1'b1;
      at_max_q   <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      zero_q     <= zero_d;
      at_max_q   <= at_max_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_q;
  assign zero_o     = zero_q;
  assign at_max_o   = at_max_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_updown_digit_counter.sv
// Scoreboard bench: a value-level reference model queues expected outputs,
// a monitor compares every cycle; a second 3x16 instance checks a full run.
module tb_updown_digit_counter;

  localparam int D1 = 2;
  localparam int R1 = 10;
  localparam int MAXV = R1 ** D1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, mode = 1'b1, sat = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] count;
  logic       zero, at_max, wrap, load_err;

  logic        rst2 = 1'b1, en2 = 1'b0, mode2 = 1'b1, sat2 = 1'b0, load2 = 1'b0;
  logic [11:0] load_val2 = '0;
  logic [11:0] count2;
  logic        zero2, at_max2, wrap2, load_err2;

  updown_digit_counter #(.DIGITS(D1), .RADIX(R1)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sat_i(sat),
    .load_i(load), .load_val_i(load_val), .count_o(count), .zero_o(zero),
    .at_max_o(at_max), .wrap_o(wrap), .load_err_o(load_err));

  updown_digit_counter #(.DIGITS(3), .RADIX(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst2), .en_i(en2), .mode_i(mode2), .sat_i(sat2),
    .load_i(load2), .load_val_i(load_val2), .count_o(count2), .zero_o(zero2),
    .at_max_o(at_max2), .wrap_o(wrap2), .load_err_o(load_err2));

  int total = 0;
  int bad   = 0;

  // expected bundle: {count[7:0], zero, at_max, wrap, load_err}
  logic [11:0] exp_q[$];
  int          mv = 0;

  function automatic logic [7:0] to_packed(input int v);
    logic [7:0] p;
    int         x;
    p = '0;
    x = v;
    for (int i = 0; i < D1; i++) begin
      p[4*i +: 4] = 4'(x % R1);
      x = x / R1;
    end
    return p;
  endfunction

  task automatic model_and_push(input logic r, input logic l, input logic [7:0] lv,
                                input logic e, input logic m, input logic s);
    logic w, le;
    int   dig, pw;
    w  = 1'b0;
    le = 1'b0;
    if (r) begin
      mv = 0;
    end else if (l) begin
      mv = 0;
      pw = 1;
      for (int i = 0; i < D1; i++) begin
        dig = int'(lv[4*i +: 4]);
        if (dig >= R1) begin
          dig = R1 - 1;
          le  = 1'b1;
        end
        mv = mv + dig * pw;
        pw = pw * R1;
      end
    end else if (e) begin
      if (m) begin
        if (mv == MAXV - 1) begin
          if (!s) begin mv = 0; w = 1'b1; end
        end else mv = mv + 1;
      end else begin
        if (mv == 0) begin
          if (!s) begin mv = MAXV - 1; w = 1'b1; end
        end else mv = mv - 1;
      end
    end
    exp_q.push_back({to_packed(mv), (mv == 0), (mv == MAXV - 1), w, le});
  endtask

  // drive at negedge, return 1ns after the sampling edge
  task automatic step(input logic r, input logic l, input logic [7:0] lv,
                      input logic e, input logic m, input logic s);
    @(negedge clk);
    rst = r; load = l; load_val = lv; en = e; mode = m; sat = s;
    model_and_push(r, l, lv, e, m, s);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] exp);
    total++;
    if ({count, zero, at_max, wrap, load_err} !== exp) begin
      bad++;
      $display("FAIL %s: got cnt=%h z=%b mx=%b w=%b le=%b want cnt=%h z=%b mx=%b w=%b le=%b",
               name, count, zero, at_max, wrap, load_err,
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // monitor: the DUT presents a new output every cycle
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({count, zero, at_max, wrap, load_err} !== e) begin
          bad++;
          $display("FAIL scoreboard @%0t: got cnt=%h z=%b mx=%b w=%b le=%b want cnt=%h z=%b mx=%b w=%b le=%b",
                   $time, count, zero, at_max, wrap, load_err,
                   e[11:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int sweep_err, sweep_wraps, n;
    logic r, l, e, m, s;
    logic [7:0] lv;

    step(1, 0, 8'h00, 1, 1, 0);
    step(1, 0, 8'h00, 1, 1, 0);
    chk("reset", {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1, 1, 0);
    chk("first_up", {8'h01, 1'b0, 1'b0, 1'b0, 1'b0});

    step(0, 1, 8'h98, 0, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    chk("up_to_max", {8'h99, 1'b0, 1'b1, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1, 1, 0);
    chk("up_wrap", {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
    step(0, 0, 8'h00, 1, 1, 0);
    chk("after_wrap", {8'h01, 1'b0, 1'b0, 1'b0, 1'b0});

    step(0, 1, 8'h10, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    chk("borrow", {8'h09, 1'b0, 1'b0, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1, 0, 0);
    chk("down", {8'h08, 1'b0, 1'b0, 1'b0, 1'b0});
    step(0, 1, 8'h00, 0, 0, 1);
    step(0, 0, 8'h00, 1, 0, 1);
    step(0, 0, 8'h00, 1, 0, 1);
    chk("down_sat", {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1, 0, 0);
    chk("down_wrap", {8'h99, 1'b0, 1'b1, 1'b1, 1'b0});
    step(0, 0, 8'h00, 1, 1, 1);
    chk("up_sat", {8'h99, 1'b0, 1'b1, 1'b0, 1'b0});

    step(0, 1, 8'hA3, 1, 1, 0);
    chk("load_clamp", {8'h93, 1'b0, 1'b0, 1'b0, 1'b1});
    step(0, 0, 8'h00, 1, 1, 0);
    chk("after_clamp", {8'h94, 1'b0, 1'b0, 1'b0, 1'b0});
    step(0, 1, 8'hFF, 0, 1, 0);
    chk("clamp_both", {8'h99, 1'b0, 1'b1, 1'b0, 1'b1});

    step(0, 1, 8'h50, 0, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    chk("dir_up1", {8'h51, 1'b0, 1'b0, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1, 1, 0);
    chk("dir_up2", {8'h52, 1'b0, 1'b0, 1'b0, 1'b0});
    step(0, 0, 8'h00, 0, 1, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    chk("hold", {8'h52, 1'b0, 1'b0, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1, 0, 0);
    chk("dir_down", {8'h51, 1'b0, 1'b0, 1'b0, 1'b0});

    step(1, 1, 8'h55, 1, 1, 0);
    chk("rst_over_load", {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});

    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 10);
      lv = 8'($urandom_range(0, 255));
      e  = ($urandom_range(0, 99) < 75);
      m  = ($urandom_range(0, 99) < 60);
      s  = ($urandom_range(0, 99) < 30);
      step(r, l, lv, e, m, s);
    end
    step(0, 0, 8'h00, 0, 1, 0);

    // full 3-digit hex run from reset, two complete periods
    sweep_err   = 0;
    sweep_wraps = 0;
    @(negedge clk);
    rst2 = 1'b1; en2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    n = 0;
    for (int k = 0; k < 8192; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (wrap2) sweep_wraps++;
      if (count2 !== 12'(n % 4096) || wrap2 !== (n % 4096 == 0) ||
          zero2 !== (n % 4096 == 0) || at_max2 !== (n % 4096 == 4095))
        sweep_err++;
    end
    en2 = 1'b0;
    total++;
    if (sweep_err != 0) begin
      bad++;
      $display("FAIL sweep_count: got %0d mismatching cycles want 0", sweep_err);
    end
    total++;
    if (sweep_wraps != 2) begin
      bad++;
      $display("FAIL sweep_wraps: got %0d want 2", sweep_wraps);
    end

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_digit_counter.md
# updown_digit_counter

Parametrised multi-digit up/down counter that generalises the single-digit 0–9 up/down counter. It supports a configurable digit count and radix, count enable, synchronous parallel load with range clamping, and a wrap or saturate end-of-range policy. Status flags and a one-cycle carry/borrow pulse allow cascading. It serves as the standard event/display counter feeding digit decoders and timers.

## Interface
- DIGITS, 2, number of digits; legal range 1–8.
- RADIX, 10, modulus of every digit; legal range 2–16. Each digit is 4 bits wide.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per cycle while high.
- mode  in  1  direction: 1 = up, 0 = down.
- sat  in  1  end-of-range policy: 1 = saturate, 0 = wrap.
- load  in  1  synchronous parallel load; overrides en.
- load_val  in  4*DIGITS  load value; digit i occupies bits [4i+3:4i]; digit 0 is the least significant.
- count  out  4*DIGITS  registered count, same packing as load_val.
- zero  out  1  high when all digits of count are 0.
- at_max  out  1  high when all digits of count are RADIX-1.
- wrap  out  1  one-cycle pulse: carry out (up) or borrow out (down) on a wrap.
- load_err  out  1  one-cycle pulse: the accepted load_val held an out-of-range digit.

## Operation
- Reset values:
  - count = 0
  - zero = 1
  - at_max = 0 (1 if DIGITS·(RADIX-1)… i.e. never 1 unless the all-max code is 0, which cannot happen for RADIX ≥ 2)
  - wrap = 0
  - load_err = 0
- Priority per cycle: rst > load > en > hold.
- Load:
  - Each digit ≥ RADIX is clamped to RADIX-1; other digits load unchanged.
  - load_err = 1 for that cycle if any digit was clamped, else 0.
  - wrap = 0 on a load cycle.
- Count up (en=1, mode=1):
  - Digit 0 increments.
  - Digit i>0 changes only when digits 0..i-1 are all RADIX-1.
  - A digit at RADIX-1 that steps goes to 0 (ripple carry).
- Count down (en=1, mode=0):
  - Digit 0 decrements.
  - Digit i>0 changes only when digits 0..i-1 are all 0.
  - A digit at 0 that steps goes to RADIX-1 (ripple borrow).
- End of range, up at all-max:
  - sat=0: count → all 0, wrap = 1.
  - sat=1: count holds, wrap = 0.
- End of range, down at all-zero:
  - sat=0: count → all RADIX-1, wrap = 1.
  - sat=1: count holds, wrap = 0.
- Hold (en=0, load=0): count unchanged; wrap = 0; load_err = 0.
- mode and sat are sampled every cycle. A direction change takes effect on the next enabled step; there is no extra idle cycle.
- Arithmetic:
  - Per-digit only; no binary add across digits.
  - Upper nibble values ≥ RADIX are unreachable except via load, and load clamps them.
- Flags are registered:
  - zero and at_max are computed from the next-count value, so they are always coherent with the count on the same cycle.
  - This differs from the predecessor, where the flag lagged the count.

## Timing
- Single clock domain, all outputs registered. No combinational path from input to output.
- Latency: inputs sampled at edge N appear on count and all flags after edge N.
- wrap and load_err are high for exactly one cycle, coincident with the new count value.
- rst asserted mid-count or together with load/en: after that edge, outputs take their reset values; load_val is ignored.
- Back-to-back enabled cycles give one step per cycle with no bubbles. Continuous up counting wraps every RADIX^DIGITS cycles.
- load and en on the same cycle: the load wins; no step is taken that cycle.

## Test plan
- Reset and flags (DIGITS=2, RADIX=10):
  - Stimulus: hold rst for 2 cycles with en=1, then release.
  - Required: count=0x00, zero=1, at_max=0, wrap=0 during reset; the first enabled up step gives 0x01, zero=0.
- Up wrap:
  - Stimulus: load 0x98, then en=1, mode=1, sat=0 for 3 cycles.
  - Required: count 0x99 (at_max=1), then 0x00 (wrap=1, zero=1), then 0x01 (wrap=0).
- Down borrow and saturation:
  - Stimulus: load 0x10, then en=1, mode=0, sat=0.
  - Required: 0x09, 0x08.
  - Then load 0x00 with sat=1 and count down for 2 cycles.
  - Required: count stays 0x00, wrap stays 0.
- Load clamp:
  - Stimulus: load_val=0xA3 with en=1.
  - Required: next count=0x93, load_err=1 for one cycle, no step applied.
  - On the following enabled up cycle: 0x94, load_err=0.
- Direction change and hold:
  - Stimulus: from 0x50, up, up, en=0 for 2 cycles, then down.
  - Required: 0x51, 0x52, 0x52, 0x52, 0x51.
- Parameter sweep:
  - Stimulus: DIGITS=3, RADIX=16, full up run from 0.
  - Required: wrap pulses exactly once per 4096 cycles; count equals the cycle count mod 4096.
